apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 186 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// ============================================================================
// apb_master_bridge
//
// APB requester stage. Accepts one transfer at a time on a valid/ready request
// port, drives it onto the APB master signals (SETUP then ACCESS phase), waits
// out PRDY wait states, and returns a single-cycle response pulse carrying the
// captured read data. This block is the only driver of the APB master signals.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   - an ACCESS wait counter aborts a transfer that sees PRDY=0 on
//               TIMEOUT_CYC consecutive ACCESS edges; the abort is reported
//               with RSP_ERR=1 and RSP_RDATA=0.
//   undefined - no counter is built, ACCESS waits indefinitely, RSP_ERR=0.
//
// Parameters:
//   AW          - address width
//   DW          - data width
//   TIMEOUT_CYC - ACCESS edges with PRDY=0 before abort (>= 2, timeout only)
//
// Ports:
//   PCLK        in   clock, all state on the rising edge
//   PRST        in   asynchronous active-low reset
//   REQ_VALID   in   request present
//   REQ_READY   out  bridge can accept a request
//   WR_RD       in   request direction (1 = write, 0 = read)
//   ADDR        in   request address
//   WDATA       in   request write data
//   PSEL        out  APB select
//   PEN         out  APB enable
//   PWR         out  APB write
//   PADDR       out  APB address
//   PWDAT       out  APB write data
//   PRDAT       in   APB read data
//   PRDY        in   APB ready
//   RSP_VALID   out  one-cycle completion pulse
//   RSP_RDATA   out  read data (0 for write completions and aborts)
//   RSP_ERR     out  completion was a timeout abort, qualified by RSP_VALID
// ============================================================================
module apb_master_bridge #(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          PCLK,
    input  logic          PRST,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic          WR_RD,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] WDATA,
    output logic          PSEL,
    output logic          PEN,
    output logic          PWR,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDAT,
    input  logic [DW-1:0] PRDAT,
    input  logic          PRDY,
    output logic          RSP_VALID,
    output logic [DW-1:0] RSP_RDATA,
    output logic          RSP_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic complete;
    logic abort;
    logic timeout_hit;

    // State register.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A request is only taken when REQ_READY is actually
    // showing, so the cycle right after reset release (IDLE but not yet
    // ready) cannot sneak an accept through. Completion is checked before
    // the timeout so PRDY=1 on the final allowed edge still completes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (PRDY) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs. Phase outputs are decoded from the next state so
    // they line up with the state register without a combinational path to
    // the pins. The APB address/data/direction only change on accept, so
    // they stay stable through the whole transfer and hold afterwards.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            REQ_READY <= 1'b0;
            PSEL      <= 1'b0;
            PEN       <= 1'b0;
            PWR       <= 1'b0;
            PADDR     <= '0;
            PWDAT     <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
        end else begin
            REQ_READY <= (state_next == IDLE);
            PSEL      <= (state_next != IDLE);
            PEN       <= (state_next == ACCESS);
            RSP_VALID <= complete | abort;
            RSP_RDATA <= (complete && !PWR) ? PRDAT : '0;
            if (accept) begin
                PWR   <= WR_RD;
                PADDR <= ADDR;
                PWDAT <= WDATA;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] wait_cnt;

    // Counts ACCESS edges that saw PRDY=0. Cleared while in SETUP so it
    // starts from zero on entry to ACCESS. When it already holds
    // TIMEOUT_CYC-1 and another PRDY=0 edge arrives, that edge is the
    // TIMEOUT_CYC-th and the transfer is aborted.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !PRDY) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout_hit = (wait_cnt == WAIT_LAST);

    // Error flag travels with the response pulse of an aborted transfer.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            RSP_ERR <= 1'b0;
        end else begin
            RSP_ERR <= abort;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign RSP_ERR            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// ============================================================================
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. A transaction-level model that
// tracks each accepted request by its age in clock edges predicts every
// output; a compare process checks the DUT against it once per cycle. Directed
// sequences add hand-computed literal expectations on top.
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge and at falling edges.
// ============================================================================
module tb_apb_master_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK      = 1'b0;
    logic          PRST      = 1'b1;
    logic          REQ_VALID = 1'b0;
    logic          WR_RD     = 1'b0;
    logic [AW-1:0] ADDR      = '0;
    logic [DW-1:0] WDATA     = '0;
    logic [DW-1:0] PRDAT     = '0;
    logic          PRDY      = 1'b0;

    logic          REQ_READY;
    logic          PSEL;
    logic          PEN;
    logic          PWR;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDAT;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_RDATA;
    logic          RSP_ERR;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .PCLK(PCLK),
        .PRST(PRST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .WR_RD(WR_RD),
        .ADDR(ADDR),
        .WDATA(WDATA),
        .PSEL(PSEL),
        .PEN(PEN),
        .PWR(PWR),
        .PADDR(PADDR),
        .PWDAT(PWDAT),
        .PRDAT(PRDAT),
        .PRDY(PRDY),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR)
    );

    always #5 PCLK = ~PCLK;

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    // ------------------------------------------------------------------------
    // Transaction-level model: a transfer is alive from its accept edge; its
    // age counts edges since accept. Age 0 is the setup cycle, every later
    // age is an access cycle, and the edge at age a >= 2 is access edge a-1.
    // ------------------------------------------------------------------------
    bit            m_active = 1'b0;
    int            m_age    = 0;
    logic          m_ready  = 1'b0;
    logic          m_psel   = 1'b0;
    logic          m_pen    = 1'b0;
    logic          m_pwr    = 1'b0;
    logic [AW-1:0] m_paddr  = '0;
    logic [DW-1:0] m_pwdat  = '0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata  = '0;
    logic          m_rerr   = 1'b0;

    task automatic modelStep();
        if (!PRST) begin
            m_active = 1'b0;
            m_age    = 0;
            m_ready  = 1'b0;
            m_psel   = 1'b0;
            m_pen    = 1'b0;
            m_pwr    = 1'b0;
            m_paddr  = '0;
            m_pwdat  = '0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_rerr   = 1'b0;
        end else begin
            m_rvalid = 1'b0;
            m_rdata  = '0;
            m_rerr   = 1'b0;
            if (!m_active) begin
                if (REQ_VALID && m_ready) begin
                    m_active = 1'b1;
                    m_age    = 0;
                    m_pwr    = WR_RD;
                    m_paddr  = ADDR;
                    m_pwdat  = WDATA;
                end
            end else begin
                m_age++;
                if (m_age >= 2) begin
                    if (PRDY) begin
                        m_active = 1'b0;
                        m_rvalid = 1'b1;
                        m_rdata  = m_pwr ? '0 : PRDAT;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (m_age - 1 == TO) begin
                        m_active = 1'b0;
                        m_rvalid = 1'b1;
                        m_rerr   = 1'b1;
                    end
`endif
                end
            end
            m_ready = !m_active;
            m_psel  = m_active;
            m_pen   = m_active && (m_age >= 1);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(posedge PCLK);
            modelStep();
            #1;
            checkOutput("model_req_ready", REQ_READY, m_ready);
            checkOutput("model_psel", PSEL, m_psel);
            checkOutput("model_pen", PEN, m_pen);
            checkOutput("model_pwr", PWR, m_pwr);
            checkOutput("model_paddr", PADDR, m_paddr);
            checkOutput("model_pwdat", PWDAT, m_pwdat);
            checkOutput("model_rsp_valid", RSP_VALID, m_rvalid);
            checkOutput("model_rsp_rdata", RSP_RDATA, m_rdata);
            checkOutput("model_rsp_err", RSP_ERR, m_rerr);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive a request (called at a falling edge) and hold it until the
    // accept edge has passed; returns at the falling edge of the setup cycle.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n         = 0;
        REQ_VALID = 1'b1;
        WR_RD     = wr;
        ADDR      = a;
        WDATA     = d;
        while (!REQ_READY && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkOutput("req_ready_wait", REQ_READY, 1'b1);
        tick();
        REQ_VALID = 1'b0;
    endtask

    initial begin
        int  pen_cycles;
        int  n;
        bit  seen;
        bit  all_high;

        // Reset values
        #1 PRST = 1'b0;
        #2;
        checkOutput("rst_req_ready", REQ_READY, 1'b0);
        checkOutput("rst_psel", PSEL, 1'b0);
        checkOutput("rst_pen", PEN, 1'b0);
        checkOutput("rst_pwdat", PWDAT, 32'h0);
        checkOutput("rst_rsp_rdata", RSP_RDATA, 32'h0);
        checkOutput("rst_rsp_valid", RSP_VALID, 1'b0);
        tick();
        tick();
        PRST = 1'b1;
        #1 checkOutput("rel_req_ready_low", REQ_READY, 1'b0);
        tick();
        checkOutput("rel_req_ready_high", REQ_READY, 1'b1);

        // Write, zero wait states
        PRDY = 1'b1;
        applyStimulus(1'b1, 8'h3C, 32'hDEADBEEF);
        checkOutput("wr_setup_psel", PSEL, 1'b1);
        checkOutput("wr_setup_pen", PEN, 1'b0);
        checkOutput("wr_setup_pwr", PWR, 1'b1);
        checkOutput("wr_setup_paddr", PADDR, 8'h3C);
        checkOutput("wr_setup_pwdat", PWDAT, 32'hDEADBEEF);
        tick();
        checkOutput("wr_access_psel", PSEL, 1'b1);
        checkOutput("wr_access_pen", PEN, 1'b1);
        tick();
        checkOutput("wr_rsp_valid", RSP_VALID, 1'b1);
        checkOutput("wr_rsp_err", RSP_ERR, 1'b0);
        checkOutput("wr_rsp_rdata", RSP_RDATA, 32'h0);
        checkOutput("wr_rsp_psel", PSEL, 1'b0);
        checkOutput("wr_rsp_ready", REQ_READY, 1'b1);
        tick();
        checkOutput("wr_pulse_once", RSP_VALID, 1'b0);

        // Read, three wait states
        PRDY  = 1'b0;
        PRDAT = 32'h0;
        applyStimulus(1'b0, 8'h10, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput("rd_access_pen", PEN, 1'b1);
            checkOutput("rd_access_paddr", PADDR, 8'h10);
            checkOutput("rd_access_rsp", RSP_VALID, 1'b0);
            if (i == 4) begin
                PRDY  = 1'b1;
                PRDAT = 32'h12345678;
            end
        end
        tick();
        PRDAT = 32'hA5A5A5A5;
        checkOutput("rd_rsp_valid", RSP_VALID, 1'b1);
        checkOutput("rd_rsp_rdata", RSP_RDATA, 32'h12345678);
        checkOutput("rd_rsp_pen", PEN, 1'b0);
        tick();

        // Back-to-back with REQ_VALID held high
        PRDY      = 1'b1;
        PRDAT     = 32'hCAFE0001;
        REQ_VALID = 1'b1;
        WR_RD     = 1'b1;
        ADDR      = 8'h04;
        WDATA     = 32'h0BADF00D;
        tick();
        checkOutput("b2b_first_setup_psel", PSEL, 1'b1);
        checkOutput("b2b_first_paddr", PADDR, 8'h04);
        WR_RD = 1'b0;
        ADDR  = 8'h08;
        tick();
        checkOutput("b2b_first_access_pen", PEN, 1'b1);
        tick();
        checkOutput("b2b_first_rsp_valid", RSP_VALID, 1'b1);
        checkOutput("b2b_gap_psel", PSEL, 1'b0);
        checkOutput("b2b_gap_ready", REQ_READY, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        checkOutput("b2b_second_setup_psel", PSEL, 1'b1);
        checkOutput("b2b_second_setup_pen", PEN, 1'b0);
        checkOutput("b2b_second_paddr", PADDR, 8'h08);
        checkOutput("b2b_second_pwr", PWR, 1'b0);
        tick();
        checkOutput("b2b_second_access_pen", PEN, 1'b1);
        tick();
        checkOutput("b2b_second_rsp_valid", RSP_VALID, 1'b1);
        checkOutput("b2b_second_rsp_rdata", RSP_RDATA, 32'hCAFE0001);
        tick();

        // REQ_VALID pulses while busy are ignored
        PRDY = 1'b0;
        applyStimulus(1'b1, 8'h20, 32'h11112222);
        REQ_VALID = 1'b1;
        ADDR      = 8'h55;
        tick();
        checkOutput("busy_paddr_a", PADDR, 8'h20);
        REQ_VALID = 1'b0;
        tick();
        REQ_VALID = 1'b1;
        ADDR      = 8'h66;
        tick();
        checkOutput("busy_paddr_b", PADDR, 8'h20);
        REQ_VALID = 1'b0;
        PRDY      = 1'b1;
        tick();
        checkOutput("busy_rsp_valid", RSP_VALID, 1'b1);
        tick();
        checkOutput("busy_no_extra_psel", PSEL, 1'b0);
        tick();
        checkOutput("busy_no_extra_psel2", PSEL, 1'b0);
        checkOutput("busy_paddr_held", PADDR, 8'h20);

        // Reset in the middle of ACCESS
        PRDY = 1'b0;
        applyStimulus(1'b0, 8'h30, 32'h0);
        tick();
        tick();
        PRST = 1'b0;
        #1;
        checkOutput("mid_rst_psel", PSEL, 1'b0);
        checkOutput("mid_rst_pen", PEN, 1'b0);
        checkOutput("mid_rst_rsp_valid", RSP_VALID, 1'b0);
        checkOutput("mid_rst_paddr", PADDR, 8'h00);
        tick();
        tick();
        PRST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RSP_VALID || PSEL) seen = 1'b1;
        end
        checkOutput("mid_rst_no_response", seen, 1'b0);

        // PRDY held low: timeout abort, or indefinite wait without the feature
        PRDY = 1'b0;
        applyStimulus(1'b1, 8'h44, 32'h00000005);
`ifdef APB_TIMEOUT_EN
        pen_cycles = 0;
        n          = 0;
        seen       = 1'b0;
        while (!seen && n < 110) begin
            tick();
            n++;
            if (RSP_VALID) seen = 1'b1;
            else if (PEN) pen_cycles++;
        end
        checkOutput("to_response_seen", seen, 1'b1);
        checkOutput("to_access_cycles", pen_cycles, TO);
        checkOutput("to_rsp_err", RSP_ERR, 1'b1);
        checkOutput("to_rsp_rdata", RSP_RDATA, 32'h0);
        checkOutput("to_psel_dropped", PSEL, 1'b0);
        checkOutput("to_pen_dropped", PEN, 1'b0);
`else
        all_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!(PSEL && PEN) || RSP_VALID) all_high = 1'b0;
        end
        checkOutput("nto_held_100", all_high, 1'b1);
        PRDY = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (RSP_VALID) seen = 1'b1;
        end
        checkOutput("nto_response_seen", seen, 1'b1);
        checkOutput("nto_rsp_err", RSP_ERR, 1'b0);
`endif
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
